axis_gmii_preamble_strip: RTL
=============================

AXIS_GMII_PREAMBLE_STRIP -- requirements
Module: axis_gmii_preamble_strip

Interface
REQ-001 The parameter MIN_FRAME_LEN SHALL default to 64 and SHALL give the minimum legal frame length in bytes after SFD, including FCS.
REQ-002 The parameter PREAMBLE_CHECK SHALL default to 1; when set, at least one 0x55 byte SHALL precede SFD; when 0, SFD SHALL be accepted as the first byte.
REQ-003 clk  input  1  sole clock; every register SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low; one clock, no other clock or reset.
REQ-005 gmii_rxd  input  8  receive byte, sampled every cycle.
REQ-006 gmii_rx_dv  input  1  receive data valid; frame spans one contiguous high run.
REQ-007 gmii_rx_er  input  1  receive error, meaningful only while gmii_rx_dv=1.
REQ-008 m_axis_tdata  output  8  frame byte after SFD (payload plus FCS).
REQ-009 m_axis_tvalid  output  1  byte valid; there is no tready, so the sink SHALL always accept.
REQ-010 m_axis_tlast  output  1  marks the last byte of a frame.
REQ-011 m_axis_tuser  output  1  bad-frame flag, valid only with tlast.
REQ-012 busy  output  1  state is not IDLE.
REQ-013 error_framing  output  1  one-cycle pulse on a preamble or SFD violation.
REQ-014 error_bad_frame  output  1  one-cycle pulse coincident with tlast when tuser=1.
REQ-015 error_short_frame  output  1  one-cycle pulse coincident with tlast when the frame is shorter than MIN_FRAME_LEN.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, PREAMBLE, PAYLOAD and WAIT_END.
REQ-017 IDLE transitions SHALL be:
- dv=1 and rxd=0x55 -> PREAMBLE.
- dv=1, rxd=0xD5 and PREAMBLE_CHECK=0 -> PAYLOAD.
- any other dv=1 byte -> WAIT_END, with error_framing pulsed.
- dv=0 -> stay in IDLE; rx_er is ignored.
REQ-018 PREAMBLE transitions SHALL be:
- 0x55 -> stay.
- 0xD5 -> PAYLOAD.
- other byte, or rx_er=1 -> WAIT_END, with error_framing pulsed.
- dv=0 -> IDLE, with error_framing pulsed.
REQ-019 WAIT_END SHALL produce no output and SHALL return to IDLE on the first cycle with dv=0.
REQ-020 In PAYLOAD, each dv=1 byte SHALL be loaded into a one-byte hold register; if the hold register was already full, its previous byte SHALL be emitted with tvalid=1 and tlast=0.
REQ-021 In PAYLOAD, a cycle with dv=0 SHALL emit the held byte with tvalid=1 and tlast=1, then the FSM SHALL go to IDLE.
REQ-022 Latency SHALL be fixed: a byte present on gmii_rxd in cycle N SHALL appear on m_axis in cycle N+2; tlast SHALL appear in the cycle after dv falls.
REQ-023 m_axis_* SHALL be registered outputs; tvalid SHALL be high for exactly one cycle per byte and SHALL not be asserted outside PAYLOAD-derived output.
REQ-024 A sticky error flag SHALL be set by rx_er=1 on any PAYLOAD byte and SHALL clear on entry to PAYLOAD.
REQ-025 A 16-bit length counter SHALL clear on SFD, increment on each PAYLOAD byte, and saturate at 0xFFFF without wrapping.
REQ-026 At tlast, short SHALL equal (count < MIN_FRAME_LEN), tuser SHALL equal (sticky error OR short), and error_bad_frame and error_short_frame SHALL pulse accordingly.
REQ-027 If dv falls while the hold register is empty (SFD immediately followed by dv=0), the block SHALL emit no output, SHALL pulse error_framing, and SHALL go to IDLE.
REQ-028 Back-to-back frames SHALL be supported: the tlast cycle may coincide with the first preamble byte of the next frame only if the FSM is already in IDLE; with a one-cycle IPG, no byte SHALL be lost.
REQ-029 busy SHALL be registered and SHALL be high in the cycle after the FSM leaves IDLE.

Reset
REQ-030 While rst_n=0, the FSM SHALL be in IDLE and the hold register empty; m_axis_tvalid, tlast, tuser, busy and all error pulses SHALL be 0; the counter and sticky error flag SHALL be 0.
REQ-031 Deasserting reset mid-frame (dv=1, data byte) SHALL lead to WAIT_END with an error_framing pulse, and SHALL produce no partial frame output.

Verification
REQ-032 Seven 0x55, then 0xD5, then 64 bytes 0x00..0x3F, then dv=0 -> 64 beats in order with tlast on 0x3F, tuser=0, no error pulses, first byte two cycles after input.
REQ-033 Same frame with rx_er=1 on byte 10 -> 64 beats, tuser=1 at tlast, error_bad_frame pulse, error_short_frame=0.
REQ-034 Preamble, SFD, 20 bytes, dv=0 -> 20 beats, tuser=1, error_bad_frame and error_short_frame pulses.
REQ-035 dv=1 with first byte 0xAA for 10 cycles -> no tvalid, one error_framing pulse, busy high until dv=0.
REQ-036 Two 64-byte frames separated by one dv=0 cycle -> 128 beats, two tlast, both tuser=0.
REQ-037 PREAMBLE_CHECK=0, SFD as first byte, 64 bytes -> 64 beats, tuser=0; rst_n pulsed low at byte 30 of a second frame -> outputs 0 immediately, no tlast, then one error_framing pulse.

Source files
------------

// File: rtl/axis_gmii_preamble_strip.sv
// GMII receive front end: strips preamble/SFD and emits the frame bytes
// (payload plus FCS) as an AXI-Stream byte stream with a fixed two-cycle latency.
module axis_gmii_preamble_strip #(
  parameter int MIN_FRAME_LEN  = 64,
  parameter bit PREAMBLE_CHECK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_dv,
  input  logic       gmii_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       busy,
  output logic       error_framing,
  output logic       error_bad_frame,
  output logic       error_short_frame,
  output logic [1:0] dbg_state
);

  // Handshake: m_axis has no tready. Every cycle with m_axis_tvalid=1 is a
  // transferred beat; the sink must accept it. tuser is meaningful only with tlast.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_PAYLOAD  = 2'd2,
    S_WAIT_END = 2'd3
  } state_t;

  localparam logic [7:0] BYTE_PRE = 8'h55;
  localparam logic [7:0] BYTE_SFD = 8'hD5;

  state_t      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [15:0] count_q, count_d;
  logic        sticky_q, sticky_d;

  logic [7:0]  tdata_d;
  logic        tvalid_d, tlast_d, tuser_d;
  logic        framing_d, bad_d, short_d, busy_d;
  logic        frame_short;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == BYTE_PRE)                        state_d = S_PREAMBLE;
          else if (gmii_rxd == BYTE_SFD && !PREAMBLE_CHECK) state_d = S_PAYLOAD;
          else                                              state_d = S_WAIT_END;
        end
      end
      S_PREAMBLE: begin
        // rx_er outranks an otherwise valid SFD
        if (!gmii_rx_dv)                 state_d = S_IDLE;
        else if (gmii_rx_er)             state_d = S_WAIT_END;
        else if (gmii_rxd == BYTE_PRE)   state_d = S_PREAMBLE;
        else if (gmii_rxd == BYTE_SFD)   state_d = S_PAYLOAD;
        else                             state_d = S_WAIT_END;
      end
      S_PAYLOAD:  if (!gmii_rx_dv) state_d = S_IDLE;
      S_WAIT_END: if (!gmii_rx_dv) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tdata_d     = hold_q;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    framing_d   = 1'b0;
    bad_d       = 1'b0;
    short_d     = 1'b0;
    frame_short = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    count_d     = count_q;
    sticky_d    = sticky_q;
    case (state_q)
      S_IDLE:     if (gmii_rx_dv && state_d == S_WAIT_END) framing_d = 1'b1;
      S_PREAMBLE: if (state_d == S_WAIT_END || state_d == S_IDLE) framing_d = 1'b1;
      S_PAYLOAD: begin
        if (gmii_rx_dv) begin
          hold_d      = gmii_rxd;
          hold_full_d = 1'b1;
          tvalid_d    = hold_full_q;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          if (gmii_rx_er) sticky_d = 1'b1;
        end else begin
          hold_full_d = 1'b0;
          if (hold_full_q) begin
            frame_short = ({16'd0, count_q} < $unsigned(MIN_FRAME_LEN));
            tvalid_d    = 1'b1;
            tlast_d     = 1'b1;
            tuser_d     = sticky_q | frame_short;
            bad_d       = sticky_q | frame_short;
            short_d     = frame_short;
          end else begin
            // SFD followed directly by end of carrier: nothing to emit
            framing_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (state_d == S_PAYLOAD && state_q != S_PAYLOAD) begin
      count_d     = 16'd0;
      sticky_d    = 1'b0;
      hold_full_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q            <= 8'd0;
      hold_full_q       <= 1'b0;
      count_q           <= 16'd0;
      sticky_q          <= 1'b0;
      m_axis_tdata      <= 8'd0;
      m_axis_tvalid     <= 1'b0;
      m_axis_tlast      <= 1'b0;
      m_axis_tuser      <= 1'b0;
      busy              <= 1'b0;
      error_framing     <= 1'b0;
      error_bad_frame   <= 1'b0;
      error_short_frame <= 1'b0;
    end else begin
      hold_q            <= hold_d;
      hold_full_q       <= hold_full_d;
      count_q           <= count_d;
      sticky_q          <= sticky_d;
      m_axis_tdata      <= tdata_d;
      m_axis_tvalid     <= tvalid_d;
      m_axis_tlast      <= tlast_d;
      m_axis_tuser      <= tuser_d;
      busy              <= busy_d;
      error_framing     <= framing_d;
      error_bad_frame   <= bad_d;
      error_short_frame <= short_d;
    end
  end

  assign dbg_state = state_q;

endmodule
